pc_register_b32: RTL and testbench

- 32-bit program-counter register for the processor fetch stage.
- Holds the current instruction address and loads a new one when write-enabled. Provides the sequential next address (PC+4) and a misalignment status to fetch and branch logic.
- Sits between next-PC mux (drives PCin/wEn) and instruction-memory address port (consumes PCout).

---
 rtl/pc_register_b32_pkg.sv | 13 +
 rtl/pc_register_b32_if.sv | 26 ++
 rtl/pc_register_b32_history4.sv | 46 ++++
 rtl/pc_register_b32.sv | 64 ++++++
 tb/tb_pc_register_b32.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/pc_register_b32_pkg.sv
// Shared types, constants and helpers for the fetch-stage program counter.
package pc_pkg;

  typedef logic [31:0] pc_t;

  localparam pc_t PC_RESET_VECTOR = 32'h0000_0000;
  localparam pc_t PC_INC          = 32'h0000_0004;

  function automatic logic pc_is_aligned(input pc_t pc);
    return (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_register_b32_if.sv
// Bus between the next-PC mux, the PC register and the instruction-memory address port.
interface pc_register_b32_if #(parameter int WIDTH = 32);

  logic             wEn;
  logic [WIDTH-1:0] PCin;
  logic [WIDTH-1:0] PCout;
  logic [WIDTH-1:0] PCplus4;
  logic             misaligned;

  modport master (
    output wEn,
    output PCin,
    input  PCout,
    input  PCplus4,
    input  misaligned
  );

  modport slave (
    input  wEn,
    input  PCin,
    output PCout,
    output PCplus4,
    output misaligned
  );

endinterface

// File: rtl/pc_register_b32_history4.sv
// Four-deep history of previously held PC values with a combinational read port.
module pc_history4
  import pc_pkg::*;
#(
  parameter pc_t RESET_VECTOR = PC_RESET_VECTOR
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_shift,
  input  pc_t        i_old_pc,
  input  logic [1:0] i_sel,
  output pc_t        o_pc
);

  pc_t r_hist [4];

  // Entry 0 receives the PC being replaced; older entries age towards 3.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        r_hist[i] <= RESET_VECTOR;
      end
    end else if (i_shift) begin
      r_hist[0] <= i_old_pc;
      for (int i = 1; i < 4; i++) begin
        r_hist[i] <= r_hist[i-1];
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_hist[i] <= r_hist[i];
      end
    end
  end

  always_comb begin
    o_pc = RESET_VECTOR;
    case (i_sel)
      2'd0:    o_pc = r_hist[0];
      2'd1:    o_pc = r_hist[1];
      2'd2:    o_pc = r_hist[2];
      2'd3:    o_pc = r_hist[3];
      default: o_pc = RESET_VECTOR;
    endcase
  end

endmodule

// File: rtl/pc_register_b32.sv
// Fetch-stage program counter with PC+INC output and sticky misalignment flag.
// Optional history of previous PCs enabled by defining PC_REG_HISTORY_EN.
module pc_register_b32
  import pc_pkg::*;
#(
  parameter int  WIDTH        = 32,
  parameter pc_t RESET_VECTOR = PC_RESET_VECTOR,
  parameter pc_t INC          = PC_INC
) (
  input  logic                clock,
  input  logic                reset,
  pc_register_b32_if.slave    bus
`ifdef PC_REG_HISTORY_EN
  ,
  input  logic [1:0]          hist_sel,
  output pc_t                 hist_pc
`endif
);

  logic [WIDTH-1:0] r_pc;
  logic             r_misaligned;
  logic [WIDTH-1:0] w_pc_next_seq;
  logic             w_load_misaligned;

  assign w_load_misaligned = ~pc_is_aligned(bus.PCin);

  // Reset outranks a load; the misaligned flag only clears on reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pc         <= RESET_VECTOR;
      r_misaligned <= 1'b0;
    end else if (bus.wEn) begin
      r_pc         <= bus.PCin;
      r_misaligned <= r_misaligned | w_load_misaligned;
    end else begin
      r_pc         <= r_pc;
      r_misaligned <= r_misaligned;
    end
  end

  assign w_pc_next_seq  = r_pc + INC;
  assign bus.PCout      = r_pc;
  assign bus.PCplus4    = w_pc_next_seq;
  assign bus.misaligned = r_misaligned;

`ifdef PC_REG_HISTORY_EN
  logic w_hist_shift;

  // Reloading the current value is not a change of PC, so it leaves history alone.
  assign w_hist_shift = reset & bus.wEn & (bus.PCin != r_pc);

  pc_history4 #(
    .RESET_VECTOR (RESET_VECTOR)
  ) u_history (
    .clock    (clock),
    .reset    (reset),
    .i_shift  (w_hist_shift),
    .i_old_pc (r_pc),
    .i_sel    (hist_sel),
    .o_pc     (hist_pc)
  );
`endif

endmodule

// File: tb/tb_pc_register_b32.sv
// Self-checking bench for pc_register_b32: directed table, random and toggling stimulus.
module tb_pc_register_b32;
  import pc_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  logic [31:0] m_pc;
  logic        m_mis;

  pc_register_b32_if bus_if ();

`ifdef PC_REG_HISTORY_EN
  logic [1:0]  hist_sel;
  logic [31:0] hist_pc;
`endif

  pc_register_b32 dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus_if.slave)
`ifdef PC_REG_HISTORY_EN
    ,
    .hist_sel (hist_sel),
    .hist_pc  (hist_pc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wen;
    logic [31:0] pcin;
    logic [31:0] exp_pc;
    logic [31:0] exp_p4;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour written directly from the register's rules.
  task automatic model_edge(input logic r, input logic w, input logic [31:0] d);
    if (r == 1'b0) begin
      m_pc  = RV;
      m_mis = 1'b0;
    end else if (w == 1'b1) begin
      m_pc = d;
      if ((d % 4) != 0) m_mis = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_pc"}, bus_if.PCout, m_pc);
    check({tag, "_p4"}, bus_if.PCplus4, m_pc + 32'd4);
    check({tag, "_mis"}, {31'd0, bus_if.misaligned}, {31'd0, m_mis});
  endtask

  task automatic drive_edge(input logic r, input logic w, input logic [31:0] d);
    rst           = r;
    bus_if.wEn    = w;
    bus_if.PCin   = d;
    @(posedge clk);
    model_edge(r, w, d);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    m_pc  = RV;
    m_mis = 1'b0;
    rst = 1'b0;
    bus_if.wEn  = 1'b0;
    bus_if.PCin = 32'h0000_0000;
`ifdef PC_REG_HISTORY_EN
    hist_sel = 2'd0;
`endif

    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0000_0000, 32'h0000_0004, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 32'h0000_0002, 32'h0000_0002, 32'h0000_0006, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 32'hFFFF_FFFD, 32'h0000_0002, 32'h0000_0006, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 32'hFFFF_FFFD, 32'h0000_0002, 32'h0000_0006, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 32'hFFFF_FFFD, 32'h0000_0002, 32'h0000_0006, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_0104, 32'h0000_0104, 32'h0000_0108, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 32'h0000_0003, 32'h0000_0003, 32'h0000_0007, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 32'h0000_0008, 32'h0000_0008, 32'h0000_000C, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0040, 32'h0000_0000, 32'h0000_0004, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0020, 32'h0000_0024, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0020, 32'h0000_0024, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      drive_edge(vecs[i].rst, vecs[i].wen, vecs[i].pcin);
      check($sformatf("vec%0d_pc", i), bus_if.PCout, vecs[i].exp_pc);
      check($sformatf("vec%0d_p4", i), bus_if.PCplus4, vecs[i].exp_p4);
      check($sformatf("vec%0d_mis", i), {31'd0, bus_if.misaligned}, {31'd0, vecs[i].exp_mis});
    end

    // Random traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic        r;
      logic        w;
      logic [31:0] d;
      r = ($urandom_range(0, 15) != 0);
      w = $urandom_range(0, 1) == 1;
      d = $urandom;
      if ($urandom_range(0, 3) != 0) d[1:0] = 2'b00;
      drive_edge(r, w, d);
      check_model($sformatf("rnd%0d", i));
    end

    // Inputs inverted every 5 ns, offset from the clock edges.
    for (int phase = 0; phase < 3; phase++) begin
      rst         = (phase != 2);
      bus_if.wEn  = (phase == 0);
      bus_if.PCin = (phase == 0) ? 32'h0000_0201 : 32'h0000_0444;
      fork
        begin
          #1;
          repeat (40) begin
            rst         = ~rst;
            bus_if.wEn  = ~bus_if.wEn;
            bus_if.PCin = ~bus_if.PCin;
            #5;
          end
        end
        begin
          repeat (20) begin
            @(posedge clk);
            model_edge(rst, bus_if.wEn, bus_if.PCin);
            #1;
            check_model($sformatf("tog%0d", phase));
          end
        end
      join
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
